// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width default, client FSM states and request/vector record layouts
package gcd_pkg;
  localparam int GCD_XLEN = 16;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} client_state_e;
  typedef struct packed {
    logic [GCD_XLEN-1:0] a;
    logic [GCD_XLEN-1:0] b;
  } gcd_req_t;
  typedef struct packed {
    logic [GCD_XLEN-1:0] a;
    logic [GCD_XLEN-1:0] b;
    logic [GCD_XLEN-1:0] exp;
  } gcd_vec_t;
endpackage

// File: rtl/gcd_vec_table.sv
// gcd_vec_table: vector register file, synchronous write, combinational read, contents never reset
module gcd_vec_table #(
  parameter int XLEN = 16,
  parameter int NVEC = 8,
  localparam int IDXW = $clog2(NVEC)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  logic [XLEN-1:0] wa,
  input  logic [XLEN-1:0] wb,
  input  logic [XLEN-1:0] wexp,
  input  logic [IDXW-1:0] raddr,
  output logic [XLEN-1:0] ra,
  output logic [XLEN-1:0] rb,
  output logic [XLEN-1:0] rexp
);
  logic [XLEN-1:0] a_mem [NVEC];
  logic [XLEN-1:0] b_mem [NVEC];
  logic [XLEN-1:0] e_mem [NVEC];
  always_ff @(posedge clk) begin
    if (we) begin
      a_mem[waddr] <= wa;
      b_mem[waddr] <= wb;
      e_mem[waddr] <= wexp;
    end
  end
  assign ra   = a_mem[raddr];
  assign rb   = b_mem[raddr];
  assign rexp = e_mem[raddr];
endmodule

// File: rtl/gcd_client.sv
// gcd_client: runs a table of (a, b, expected) vectors through a val/rdy GCD unit and tallies results
module gcd_client
  import gcd_pkg::*;
#(
  parameter int XLEN = GCD_XLEN,
  parameter int NVEC = 8,
  parameter int TIMEOUT = 255,
  localparam int IDXW = $clog2(NVEC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDXW-1:0]   cfg_addr,
  input  logic [XLEN-1:0]   cfg_a,
  input  logic [XLEN-1:0]   cfg_b,
  input  logic [XLEN-1:0]   cfg_exp,
  input  logic              start,
  input  logic [IDXW:0]     num_vec,
  output logic              req_val,
  input  logic              req_rdy,
  output logic [2*XLEN-1:0] req_msg,
  input  logic              resp_val,
  output logic              resp_rdy,
  input  logic [XLEN-1:0]   resp_msg,
  output logic              busy,
  output logic              done,
  output logic [IDXW:0]     pass_cnt,
  output logic [IDXW:0]     fail_cnt,
  output logic [IDXW-1:0]   first_fail_idx,
  output logic              fail_seen,
  output logic              timeout,
  output logic [31:0]       cycle_cnt
);
  localparam int NW = IDXW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  client_state_e state, state_n;
  logic [NW-1:0] n;
  logic [IDXW-1:0] idx;
  logic [TW-1:0] wcnt;
  logic [XLEN-1:0] rd_a, rd_b, rd_exp;
  logic launch, last, tmo;
  gcd_vec_table #(.XLEN(XLEN), .NVEC(NVEC)) u_table (
    .clk   (clk),
    .we    (cfg_we && !busy),
    .waddr (cfg_addr),
    .wa    (cfg_a),
    .wb    (cfg_b),
    .wexp  (cfg_exp),
    .raddr (idx),
    .ra    (rd_a),
    .rb    (rd_b),
    .rexp  (rd_exp)
  );
  assign busy     = state == SEND || state == WAIT;
  assign done     = state == DONE;
  assign req_val  = state == SEND;
  assign resp_rdy = state == WAIT;
  assign req_msg  = req_val ? {rd_a, rd_b} : '0;
  assign launch   = start && !busy;
  assign last     = {1'b0, idx} == n - NW'(1);
  assign tmo      = state == WAIT && !resp_val && wcnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = num_vec == '0 ? DONE : SEND;
      SEND:       if (req_rdy) state_n = WAIT;
      WAIT:       state_n = resp_val ? (last ? DONE : SEND) : (tmo ? DONE : WAIT);
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      n              <= '0;
      idx            <= '0;
      wcnt           <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
      timeout        <= 1'b0;
      cycle_cnt      <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        n              <= num_vec > NW'(NVEC) ? NW'(NVEC) : num_vec;
        idx            <= '0;
        wcnt           <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_idx <= '0;
        fail_seen      <= 1'b0;
        timeout        <= 1'b0;
        cycle_cnt      <= '0;
      end else begin
        if (busy && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
        if (state == SEND) wcnt <= '0;
        if (state == WAIT && !resp_val) wcnt <= wcnt + TW'(1);
        if (state == WAIT && resp_val) begin
          if (resp_msg == rd_exp) pass_cnt <= pass_cnt + NW'(1);
          else begin
            fail_cnt <= fail_cnt + NW'(1);
            if (!fail_seen) begin
              first_fail_idx <= idx;
              fail_seen      <= 1'b1;
            end
          end
          if (!last) idx <= idx + IDXW'(1);
        end
        // a timed-out vector counts as a failure but does not record an index
        if (tmo) begin
          timeout  <= 1'b1;
          fail_cnt <= fail_cnt + NW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed/randomized run of gcd_client against a behavioural GCD responder and table model
module tb_gcd_client;
  import gcd_pkg::*;
  logic clk = 1'b0;
  logic reset, cfg_we, start, req_val, req_rdy, resp_val, resp_rdy;
  logic busy, done, fail_seen, timeout;
  logic [2:0] cfg_addr, first_fail_idx;
  logic [15:0] cfg_a, cfg_b, cfg_exp, resp_msg;
  logic [3:0] num_vec, pass_cnt, fail_cnt;
  logic [31:0] req_msg, cycle_cnt, first_msg;
  int checks = 0, failures = 0, cyc = 0, xfers = 0, xfer_cyc = 0, stub_cycles = 0;
  int rdy_dly = 0, resp_lat = 1;
  bit rnd = 0, no_resp = 0, unstable = 0;
  int unsigned ta [8], tbv [8], te [8];

  gcd_client dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a),
    .cfg_b(cfg_b), .cfg_exp(cfg_exp), .start(start), .num_vec(num_vec),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .resp_val(resp_val),
    .resp_rdy(resp_rdy), .resp_msg(resp_msg), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .fail_seen(fail_seen), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  function automatic int unsigned ref_gcd(int unsigned x, int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD unit stand-in: all driving happens on falling edges
  initial begin
    gcd_req_t rq;
    int rd, lt;
    req_rdy = 0; resp_val = 0; resp_msg = 0;
    forever begin
      if (req_val && !reset) begin
        rd = rnd ? int'($urandom_range(0, 3)) : rdy_dly;
        lt = rnd ? int'($urandom_range(1, 4)) : resp_lat;
        first_msg = req_msg;
        for (int i = 0; i < rd; i++) begin
          if (req_msg !== first_msg || !req_val) unstable = 1;
          @(negedge clk);
        end
        if (req_msg !== first_msg || !req_val) unstable = 1;
        req_rdy = 1;
        @(negedge clk);
        req_rdy = 0;
        xfers++;
        xfer_cyc = cyc;
        stub_cycles += rd + 1 + lt;
        rq = first_msg;
        if (!no_resp) begin
          for (int i = 1; i < lt && !reset; i++) @(negedge clk);
          if (!reset) begin
            resp_val = 1;
            resp_msg = 16'(ref_gcd(rq.a, rq.b));
            @(negedge clk);
            resp_val = 0;
            resp_msg = 0;
          end
        end
      end else @(negedge clk);
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic load(int i, int unsigned a, int unsigned b, int unsigned e);
    @(negedge clk);
    cfg_we = 1; cfg_addr = 3'(i); cfg_a = 16'(a); cfg_b = 16'(b); cfg_exp = 16'(e);
    if (!busy) begin
      ta[i] = a; tbv[i] = b; te[i] = e;
    end
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic run(int nv);
    @(negedge clk);
    stub_cycles = 0;
    xfers = 0;
    num_vec = 4'(nv);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(string tag);
    int g;
    g = 0;
    while (!done && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic check_results(string tag, int nv);
    int n, p, f, ff;
    n = nv > 8 ? 8 : nv;
    p = 0; f = 0; ff = -1;
    for (int i = 0; i < n; i++)
      if (ref_gcd(ta[i], tbv[i]) == te[i]) p++;
      else begin
        f++;
        if (ff < 0) ff = i;
      end
    chk({tag, "_pass"}, pass_cnt, p);
    chk({tag, "_fail"}, fail_cnt, f);
    chk({tag, "_fail_seen"}, fail_seen, f != 0);
    if (ff >= 0) chk({tag, "_first_fail"}, first_fail_idx, ff);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cycles"}, cycle_cnt, stub_cycles);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int unsigned g, a, b;
    int guard;
    reset = 1; cfg_we = 0; cfg_addr = 0; cfg_a = 0; cfg_b = 0; cfg_exp = 0;
    start = 0; num_vec = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req_val", req_val, 0);
    chk("rst_req_msg", req_msg, 0);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_counts", {pass_cnt, fail_cnt, 3'(first_fail_idx), fail_seen, timeout}, 0);
    chk("rst_cycles", cycle_cnt, 0);
    reset = 0;
    load(0, 48, 18, 6);
    load(1, 1701, 199, 1);
    load(2, 22000, 19900, 100);
    load(3, 42000, 1990, 10);
    load(4, 17, 289, 17);
    load(5, 40664, 57408, 2392);
    for (int i = 6; i < 8; i++) begin
      g = $urandom_range(1, 50);
      a = g * $urandom_range(1, 1000);
      b = g * $urandom_range(1, 1000);
      load(i, a, b, ref_gcd(a, b));
    end

    rnd = 1;
    run(6);
    chk("all6_busy_after_start", busy, 1);
    wait_done("all6");
    check_results("all6", 6);
    chk("all6_req_msg_idle", req_msg, 0);

    load(3, 42000, 1990, 11);
    run(6);
    chk("corrupt_done_cleared", done, 0);
    chk("corrupt_pass_cleared", pass_cnt, 0);
    wait_done("corrupt");
    check_results("corrupt", 6);
    load(3, 42000, 1990, 10);

    rnd = 0; rdy_dly = 5; resp_lat = 3; unstable = 0;
    run(1);
    wait_done("stall");
    chk("stall_stable", unstable, 0);
    chk("stall_msg", first_msg, {16'd48, 16'd18});
    chk("stall_xfers", xfers, 1);
    chk("stall_cycles", cycle_cnt, 9);
    chk("stall_pass", pass_cnt, 1);

    no_resp = 1; rdy_dly = 0;
    run(1);
    wait_done("tmo");
    chk("tmo_flag", timeout, 1);
    chk("tmo_fail", fail_cnt, 1);
    chk("tmo_pass", pass_cnt, 0);
    chk("tmo_wait_len", cyc - xfer_cyc, 255);
    chk("tmo_cycles", cycle_cnt, 256);
    no_resp = 0;

    run(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_counts", {pass_cnt, fail_cnt, timeout}, 0);
    chk("zero_cycles", cycle_cnt, 0);

    rnd = 1;
    run(12);
    repeat (4) @(negedge clk);
    chk("clamp_busy", busy, 1);
    num_vec = 1; start = 1;
    cfg_we = 1; cfg_addr = 0; cfg_a = 16'd5; cfg_b = 16'd7; cfg_exp = 16'd999;
    @(negedge clk);
    start = 0; cfg_we = 0;
    wait_done("clamp");
    check_results("clamp", 12);

    rnd = 0; rdy_dly = 0; resp_lat = 10;
    run(6);
    guard = 0;
    while (!(xfers == 3 && resp_rdy) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached_wait2", {xfers == 3, resp_rdy}, 2'b11);
    chk("midrst_pass_before", pass_cnt, 2);
    reset = 1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_val", req_val, 0);
    chk("midrst_resp_rdy", resp_rdy, 0);
    chk("midrst_pass", pass_cnt, 0);
    chk("midrst_cycles", cycle_cnt, 0);
    @(negedge clk);
    reset = 0;
    rnd = 1;
    run(8);
    wait_done("rerun");
    check_results("rerun", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
